// File: rtl/safety_island_dma_nd_midend_if.sv
`default_nettype none
// ============================================================================
// safety_island_dma_nd_midend_if : N-D job / 1D backend bundle for the midend
// Revision: 1.0
// ============================================================================
interface safety_island_dma_nd_midend_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int TF_LEN_WIDTH = 24,
  parameter int REP_WIDTH    = 16,
  parameter int NUM_DIMS     = 3
);
  logic                                  nd_valid;
  logic                                  nd_ready;
  logic [ADDR_WIDTH-1:0]                 src_addr;
  logic [ADDR_WIDTH-1:0]                 dst_addr;
  logic [TF_LEN_WIDTH-1:0]               length;
  logic [(NUM_DIMS-1)*ADDR_WIDTH-1:0]    src_stride;
  logic [(NUM_DIMS-1)*ADDR_WIDTH-1:0]    dst_stride;
  logic [(NUM_DIMS-1)*REP_WIDTH-1:0]     reps;
  logic                                  be_valid;
  logic                                  be_ready;
  logic [ADDR_WIDTH-1:0]                 be_src;
  logic [ADDR_WIDTH-1:0]                 be_dst;
  logic [TF_LEN_WIDTH-1:0]               be_len;
  logic                                  be_last;
  logic                                  be_rsp_valid;
  logic                                  be_rsp_err;
  logic                                  nd_done;
  logic                                  nd_err;
  logic                                  busy;

  // Environment side: frontend job source plus backend model
  modport master (
    output nd_valid, src_addr, dst_addr, length, src_stride, dst_stride, reps,
    output be_ready, be_rsp_valid, be_rsp_err,
    input  nd_ready, be_valid, be_src, be_dst, be_len, be_last,
    input  nd_done, nd_err, busy
  );

  modport slave (
    input  nd_valid, src_addr, dst_addr, length, src_stride, dst_stride, reps,
    input  be_ready, be_rsp_valid, be_rsp_err,
    output nd_ready, be_valid, be_src, be_dst, be_len, be_last,
    output nd_done, nd_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/safety_island_dma_nd_midend.sv
`default_nettype none
// ============================================================================
// safety_island_dma_nd_midend : splits an N-D DMA job into strided 1D transfers
// Revision: 1.0
// ============================================================================
module safety_island_dma_nd_midend #(
  parameter int ADDR_WIDTH      = 32,
  parameter int TF_LEN_WIDTH    = 24,
  parameter int REP_WIDTH       = 16,
  parameter int NUM_DIMS        = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  safety_island_dma_nd_midend_if.slave bus
);

  localparam int OD    = NUM_DIMS - 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]              state;
  logic [TF_LEN_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0]   src_str_q [OD];
  logic [ADDR_WIDTH-1:0]   dst_str_q [OD];
  logic [REP_WIDTH-1:0]    reps_q    [OD];
  logic [REP_WIDTH-1:0]    idx_q     [OD];
  logic [ADDR_WIDTH-1:0]   row_src_q [OD];
  logic [ADDR_WIDTH-1:0]   row_dst_q [OD];
  logic [OUT_W-1:0]        outstanding;
  logic                    err_q;

  logic [REP_WIDTH-1:0]    idx_n     [OD];
  logic [ADDR_WIDTH-1:0]   row_src_n [OD];
  logic [ADDR_WIDTH-1:0]   row_dst_n [OD];
  logic [OD-1:0]           wrap;
  logic                    last;
  logic                    carry;
  logic                    be_valid;
  logic                    hs;
  logic                    rsp_cnt;
  logic                    job_zero;
  logic [OUT_W-1:0]        outstanding_n;

  assign be_valid = (state == ST_ISSUE) && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign hs       = be_valid && bus.be_ready;
  assign rsp_cnt  = bus.be_rsp_valid && (outstanding != '0);
  assign last     = &wrap;

  always_comb begin
    wrap     = '0;
    job_zero = (bus.length == '0);
    for (int d = 0; d < OD; d++) begin
      wrap[d] = (idx_q[d] == reps_q[d] - REP_WIDTH'(1));
      if (bus.reps[d*REP_WIDTH +: REP_WIDTH] == '0) job_zero = 1'b1;
    end
  end

  always_comb begin
    outstanding_n = outstanding;
    if (hs && !rsp_cnt)      outstanding_n = outstanding + OUT_W'(1);
    else if (!hs && rsp_cnt) outstanding_n = outstanding - OUT_W'(1);
  end

  // Odometer step: lowest non-wrapping dimension increments, every row base
  // at or below it restarts from that dimension's next row address.
  always_comb begin
    idx_n     = idx_q;
    row_src_n = row_src_q;
    row_dst_n = row_dst_q;
    carry     = 1'b1;
    for (int d = 0; d < OD; d++) begin
      if (carry) begin
        if (wrap[d]) begin
          idx_n[d] = '0;
        end else begin
          idx_n[d] = idx_q[d] + REP_WIDTH'(1);
          carry    = 1'b0;
          for (int j = 0; j < OD; j++) begin
            if (j <= d) begin
              row_src_n[j] = row_src_q[d] + src_str_q[d];
              row_dst_n[j] = row_dst_q[d] + dst_str_q[d];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
      for (int d = 0; d < OD; d++) begin
        src_str_q[d] <= '0;
        dst_str_q[d] <= '0;
        reps_q[d]    <= '0;
        idx_q[d]     <= '0;
        row_src_q[d] <= '0;
        row_dst_q[d] <= '0;
      end
    end else begin
      outstanding <= outstanding_n;
      if (rsp_cnt && bus.be_rsp_err) err_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.nd_valid) begin
            len_q <= bus.length;
            err_q <= job_zero;
            state <= job_zero ? ST_DONE : ST_ISSUE;
            for (int d = 0; d < OD; d++) begin
              src_str_q[d] <= bus.src_stride[d*ADDR_WIDTH +: ADDR_WIDTH];
              dst_str_q[d] <= bus.dst_stride[d*ADDR_WIDTH +: ADDR_WIDTH];
              reps_q[d]    <= bus.reps[d*REP_WIDTH +: REP_WIDTH];
              idx_q[d]     <= '0;
              row_src_q[d] <= bus.src_addr;
              row_dst_q[d] <= bus.dst_addr;
            end
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            if (last) begin
              state <= ST_DRAIN;
            end else begin
              idx_q     <= idx_n;
              row_src_q <= row_src_n;
              row_dst_q <= row_dst_n;
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding_n == '0) state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.nd_ready = (state == ST_IDLE);
  assign bus.be_valid = be_valid;
  assign bus.be_src   = row_src_q[0];
  assign bus.be_dst   = row_dst_q[0];
  assign bus.be_len   = len_q;
  assign bus.be_last  = last;
  assign bus.nd_done  = (state == ST_DONE);
  assign bus.nd_err   = (state == ST_DONE) && err_q;
  assign bus.busy     = (state != ST_IDLE) || (outstanding != '0);

endmodule
`default_nettype wire

// File: tb/tb_safety_island_dma_nd_midend.sv
`default_nettype none
// ============================================================================
// tb_safety_island_dma_nd_midend : scoreboard bench for the N-D DMA midend
// Revision: 1.0
// ============================================================================
module tb_safety_island_dma_nd_midend;

  localparam int AW = 32;
  localparam int TL = 24;
  localparam int RW = 16;
  localparam int ND = 3;
  localparam int MO = 2;

  typedef struct {
    logic [31:0] src, dst;
    logic [23:0] len;
    logic [31:0] s1, s2, d1, d2;
    logic [15:0] r1, r2;
    int          rdy_pct, rsp_pct, err_at;
    logic        exp_err;
  } job_t;

  typedef struct {
    logic [31:0] src, dst;
    logic [23:0] len;
    logic        last;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  safety_island_dma_nd_midend_if #(.ADDR_WIDTH(AW), .TF_LEN_WIDTH(TL), .REP_WIDTH(RW),
                                   .NUM_DIMS(ND)) bus ();

  safety_island_dma_nd_midend #(.ADDR_WIDTH(AW), .TF_LEN_WIDTH(TL), .REP_WIDTH(RW),
                                .NUM_DIMS(ND), .MAX_OUTSTANDING(MO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  req_t req_q[$];
  logic done_q[$];
  req_t mon_r;
  logic mon_e;
  int   n_cmp = 0, n_err = 0;
  int   pending = 0, rsp_budget = 0, rsp_idx = 0, err_at = -1;
  int   rdy_pct = 100, rsp_pct = 100;
  int   issued = 0, done_cnt = 0;
  job_t tbl[10];

  // Backend-facing monitor: runs mid-cycle so every value is settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.be_valid && bus.be_ready) begin
        issued++;
        pending++;
        n_cmp++;
        if (req_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_req got src=%h dst=%h required none", bus.be_src, bus.be_dst);
        end else begin
          mon_r = req_q.pop_front();
          if (bus.be_src !== mon_r.src || bus.be_dst !== mon_r.dst ||
              bus.be_len !== mon_r.len || bus.be_last !== mon_r.last) begin
            n_err++;
            $display("FAIL req got src=%h dst=%h len=%h last=%b required src=%h dst=%h len=%h last=%b",
                     bus.be_src, bus.be_dst, bus.be_len, bus.be_last,
                     mon_r.src, mon_r.dst, mon_r.len, mon_r.last);
          end
        end
      end
      if (bus.nd_done) begin
        done_cnt++;
        n_cmp++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done got err=%b required no done", bus.nd_err);
        end else begin
          mon_e = done_q.pop_front();
          if (bus.nd_err !== mon_e) begin
            n_err++;
            $display("FAIL done_err got %b required %b", bus.nd_err, mon_e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.be_ready = (int'($urandom_range(99)) < rdy_pct);
    if (pending > 0 && rsp_budget > 0 && int'($urandom_range(99)) < rsp_pct) begin
      bus.be_rsp_valid = 1'b1;
      bus.be_rsp_err   = (rsp_idx == err_at);
      rsp_idx++;
      pending--;
      rsp_budget--;
    end else begin
      bus.be_rsp_valid = 1'b0;
      bus.be_rsp_err   = 1'b0;
    end
  endtask

  function automatic job_t mk(logic [31:0] src, logic [31:0] dst, logic [23:0] len,
                              logic [31:0] s1, logic [31:0] s2, logic [31:0] d1, logic [31:0] d2,
                              logic [15:0] r1, logic [15:0] r2, int rdy, int rsp, int ea, logic ee);
    job_t j;
    j.src = src; j.dst = dst; j.len = len; j.s1 = s1; j.s2 = s2; j.d1 = d1; j.d2 = d2;
    j.r1 = r1; j.r2 = r2; j.rdy_pct = rdy; j.rsp_pct = rsp; j.err_at = ea; j.exp_err = ee;
    return j;
  endfunction

  // Reference: plain address = base + i*s1 + j*s2 (mod 2^32), row-major order.
  task automatic push_job(input job_t j);
    req_t r;
    logic [31:0] ii, jj;
    if (j.r1 != 0 && j.r2 != 0 && j.len != 0) begin
      for (int b = 0; b < int'(j.r2); b++) begin
        for (int a = 0; a < int'(j.r1); a++) begin
          ii = 32'(a);
          jj = 32'(b);
          r.src  = j.src + ii * j.s1 + jj * j.s2;
          r.dst  = j.dst + ii * j.d1 + jj * j.d2;
          r.len  = j.len;
          r.last = (a == int'(j.r1) - 1) && (b == int'(j.r2) - 1);
          req_q.push_back(r);
        end
      end
    end
    done_q.push_back(j.exp_err);
    rdy_pct    = j.rdy_pct;
    rsp_pct    = j.rsp_pct;
    err_at     = j.err_at;
    rsp_idx    = 0;
    rsp_budget = 1000000;
  endtask

  task automatic accept(input job_t j);
    int w;
    bus.src_addr   = j.src;
    bus.dst_addr   = j.dst;
    bus.length     = j.len;
    bus.src_stride = {j.s2, j.s1};
    bus.dst_stride = {j.d2, j.d1};
    bus.reps       = {j.r2, j.r1};
    bus.nd_valid   = 1'b1;
    w = 0;
    while (!bus.nd_ready && w < 50) begin
      step();
      w++;
    end
    if (!bus.nd_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout got nd_ready=0 required 1");
    end
    step();
    bus.nd_valid = 1'b0;
    bus.src_addr = $urandom;
    bus.reps     = {16'h0000, 16'h0000};
  endtask

  task automatic run_job(input job_t j, input string name);
    int d0, waited;
    push_job(j);
    d0 = done_cnt;
    accept(j);
    waited = 0;
    while (done_cnt == d0 && waited < 3000) begin
      step();
      waited++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout got no done required done", name);
    end
    chk({name, "_left_reqs"}, 64'(req_q.size()), 64'd0);
    if (j.r1 == 0 || j.r2 == 0 || j.len == 0) chk({name, "_zero_latency_le2"}, 64'(waited <= 2), 64'd1);
  endtask

  initial begin
    job_t j;
    int i0, d0;
    rst = 1'b1;
    bus.nd_valid = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    bus.src_stride = '0; bus.dst_stride = '0; bus.reps = '0;
    bus.be_ready = 1'b0; bus.be_rsp_valid = 1'b0; bus.be_rsp_err = 1'b0;

    tbl[0] = mk(32'h1000, 32'h8000, 24'd64, 32'h100, 32'h0, 32'h40, 32'h0, 16'd3, 16'd1, 100, 100, -1, 1'b0);
    tbl[1] = mk(32'h0, 32'h2000, 24'd16, 32'h10, 32'h100, 32'h20, 32'h40, 16'd2, 16'd3, 70, 60, -1, 1'b0);
    tbl[2] = mk(32'h10, 32'h20, 24'd8, 32'h4, 32'h8, 32'h4, 32'h8, 16'd0, 16'd2, 100, 100, -1, 1'b1);
    tbl[3] = mk(32'h10, 32'h20, 24'd0, 32'h4, 32'h8, 32'h4, 32'h8, 16'd2, 16'd2, 100, 100, -1, 1'b1);
    tbl[4] = mk(32'h10, 32'h20, 24'd8, 32'h4, 32'h8, 32'h4, 32'h8, 16'd2, 16'd0, 100, 100, -1, 1'b1);
    tbl[5] = mk(32'h4000, 32'h5000, 24'd32, 32'h20, 32'h200, 32'h20, 32'h400, 16'd2, 16'd2, 100, 50, 2, 1'b1);
    tbl[6] = mk(32'h8, 32'h0, 24'd4, 32'hFFFF_FFF0, 32'h1000, 32'hFFFF_FFFF, 32'h0, 16'd3, 16'd2, 80, 70, -1, 1'b0);
    tbl[7] = mk(32'hFFFF_FFF0, 32'hFFFF_FF00, 24'h800000, 32'h20, 32'h4000_0000, 32'h80, 32'h8, 16'd3, 16'd3, 60, 50, -1, 1'b0);
    tbl[8] = mk(32'hABC0, 32'hDEF0, 24'd1, 32'h1, 32'h1, 32'h1, 32'h1, 16'd1, 16'd1, 100, 100, -1, 1'b0);
    tbl[9] = mk(32'h100, 32'h900, 24'd12, 32'hC, 32'h40, 32'h10, 32'h80, 16'd4, 16'd3, 50, 40, 11, 1'b1);

    #1;
    chk("rst_nd_ready", 64'(bus.nd_ready), 64'd1);
    chk("rst_be_valid", 64'(bus.be_valid), 64'd0);
    chk("rst_done_err_busy", 64'({bus.nd_done, bus.nd_err, bus.busy}), 64'd0);
    chk("rst_be_src_dst_len", {bus.be_src, bus.be_dst} | 64'(bus.be_len), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int t = 0; t < 10; t++) run_job(tbl[t], $sformatf("job%0d", t));

    // Completion with nothing outstanding must be dropped.
    @(posedge clk); #1;
    bus.be_rsp_valid = 1'b1;
    @(posedge clk); #1;
    bus.be_rsp_valid = 1'b0;
    chk("idle_rsp_busy", 64'(bus.busy), 64'd0);
    run_job(tbl[8], "after_idle_rsp");

    // Throttle: responses held back, only MO requests may be in flight.
    j = mk(32'h0, 32'h100, 24'd8, 32'h10, 32'h0, 32'h8, 32'h0, 16'd5, 16'd1, 100, 100, -1, 1'b0);
    push_job(j);
    rsp_budget = 0;
    i0 = issued;
    d0 = done_cnt;
    accept(j);
    repeat (10) step();
    chk("mo_hold_issued", 64'(issued - i0), 64'd2);
    chk("mo_hold_be_valid", 64'(bus.be_valid), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      rsp_budget = 1;
      repeat (4) step();
      chk($sformatf("mo_release%0d_issued", k), 64'(issued - i0), 64'(2 + k));
      chk($sformatf("mo_release%0d_no_done", k), 64'(done_cnt - d0), 64'd0);
    end
    rsp_budget = 1;
    repeat (4) step();
    chk("mo_4th_rsp_no_done", 64'(done_cnt - d0), 64'd0);
    rsp_budget = 1;
    repeat (4) step();
    chk("mo_5th_rsp_done", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of issuing: outputs clear, job vanishes silently.
    j = mk(32'h8, 32'h0, 24'd4, 32'hFFFF_FFF0, 32'h100, 32'h4, 32'h40, 16'd4, 16'd4, 100, 50, -1, 1'b0);
    push_job(j);
    accept(j);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("midrst_be_valid", 64'(bus.be_valid), 64'd0);
    chk("midrst_done_busy", 64'({bus.nd_done, bus.busy}), 64'd0);
    chk("midrst_be_src", 64'(bus.be_src), 64'd0);
    req_q.delete();
    done_q.delete();
    pending = 0;
    d0 = done_cnt;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_nd_ready", 64'(bus.nd_ready), 64'd1);
    run_job(tbl[1], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
